multi_data_sync: RTL and testbench

Multi-channel successor to the single-bus data synchronizer. NUM_CH independent source buses, each qualified by its own enable, are brought into the CLK domain. Each enable passes through a NUM_STAGES flop chain. Captured words are queued per channel and delivered one at a time on a shared output port by a round-robin arbiter, with a per-channel ack level returned to the sources and sticky overrun flags. It sits at the receive side of any clock-domain crossing carrying several slow control/data words.

---
 rtl/multi_data_sync.sv | 103 ++++++++++
 tb/tb_multi_data_sync.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_data_sync.sv
// Multi-channel enable-qualified bus synchronizer with per-channel hold registers,
// round-robin delivery onto one shared output port, ack levels and sticky overrun flags.
module multi_data_sync #(
   parameter int unsigned NUM_STAGES  = 2,
   parameter int unsigned BUS_WIDTH   = 8,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned TOGGLE_MODE = 0,
   parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
   input  logic [NUM_CH-1:0]             bus_enable,
   input  logic [NUM_CH-1:0]             ovr_clr,
   output logic [BUS_WIDTH-1:0]          sync_bus,
   output logic [CH_W-1:0]               sync_ch,
   output logic                          enable_pulse,
   output logic [NUM_CH-1:0]             ack,
   output logic [NUM_CH-1:0]             overrun
);

   logic [NUM_CH-1:0]    meta_q [NUM_STAGES];
   logic [NUM_CH-1:0]    sync;
   logic [NUM_CH-1:0]    prev_q;
   logic [NUM_CH-1:0]    evt;
   logic [NUM_CH-1:0]    pend_q;
   logic [NUM_CH-1:0]    ack_q;
   logic [NUM_CH-1:0]    ovr_q;
   logic [BUS_WIDTH-1:0] hold_q [NUM_CH];
   logic [CH_W-1:0]      rr_q;
   logic [CH_W-1:0]      idx;
   logic [CH_W-1:0]      gnt_idx;
   logic                 gnt_valid;
   logic [NUM_CH-1:0]    gnt_oh;
   logic [BUS_WIDTH-1:0] sync_bus_q;
   logic [CH_W-1:0]      sync_ch_q;
   logic                 pulse_q;

   assign sync = meta_q[NUM_STAGES-1];
   assign evt  = (TOGGLE_MODE != 0) ? (sync ^ prev_q) : (sync & ~prev_q);

   // Cyclic search for the first pending channel at or after the round-robin pointer.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         idx = CH_W'((32'(rr_q) + 32'(i)) % NUM_CH);
         if (!gnt_valid && pend_q[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
      gnt_oh = '0;
      if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int s = 0; s < int'(NUM_STAGES); s++) meta_q[s] <= '0;
         for (int c = 0; c < int'(NUM_CH); c++) hold_q[c] <= '0;
         prev_q     <= '0;
         pend_q     <= '0;
         ack_q      <= '0;
         ovr_q      <= '0;
         rr_q       <= '0;
         sync_bus_q <= '0;
         sync_ch_q  <= '0;
         pulse_q    <= 1'b0;
      end else begin
         meta_q[0] <= bus_enable;
         for (int s = 1; s < int'(NUM_STAGES); s++) meta_q[s] <= meta_q[s-1];
         prev_q  <= sync;
         pulse_q <= gnt_valid;
         if (gnt_valid) begin
            sync_bus_q <= hold_q[gnt_idx];
            sync_ch_q  <= gnt_idx;
            rr_q       <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(gnt_idx + 1'b1);
         end
         for (int c = 0; c < int'(NUM_CH); c++) begin
            // An occupied, ungranted slot keeps its oldest word and drops the new one.
            if (evt[c] && !(pend_q[c] && !gnt_oh[c])) begin
               hold_q[c] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
            end
            pend_q[c] <= evt[c] | (pend_q[c] & ~gnt_oh[c]);
            ovr_q[c]  <= (evt[c] & pend_q[c] & ~gnt_oh[c]) | (ovr_q[c] & ~ovr_clr[c]);
            if (TOGGLE_MODE != 0) begin
               if (gnt_oh[c]) ack_q[c] <= ~ack_q[c];
            end else begin
               if (gnt_oh[c])    ack_q[c] <= 1'b1;
               else if (!sync[c]) ack_q[c] <= 1'b0;
            end
         end
      end
   end

   assign sync_bus     = sync_bus_q;
   assign sync_ch      = sync_ch_q;
   assign enable_pulse = pulse_q;
   assign ack          = ack_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_multi_data_sync.sv
// Bench for multi_data_sync: one level-mode and one toggle-mode instance, each with a
// scoreboard queue of expected {channel, word} deliveries checked as pulses appear.
module tb_multi_data_sync;

   localparam int unsigned NCH = 4;
   localparam int unsigned BW  = 8;
   localparam int unsigned NS  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst0, rst1;
   logic [NCH*BW-1:0] bus0, bus1;
   logic [NCH-1:0]    en0, en1, clr0, clr1;
   logic [BW-1:0]     sb0, sb1;
   logic [1:0]        sc0, sc1;
   logic              p0, p1;
   logic [NCH-1:0]    ack0, ack1, ovr0, ovr1;

   int checks = 0;
   int errors = 0;
   logic [9:0] q0[$];
   logic [9:0] q1[$];

   multi_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .TOGGLE_MODE(0)) dut0 (
      .CLK(clk), .RST(rst0), .unsync_bus(bus0), .bus_enable(en0), .ovr_clr(clr0),
      .sync_bus(sb0), .sync_ch(sc0), .enable_pulse(p0), .ack(ack0), .overrun(ovr0)
   );

   multi_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .TOGGLE_MODE(1)) dut1 (
      .CLK(clk), .RST(rst1), .unsync_bus(bus1), .bus_enable(en1), .ovr_clr(clr1),
      .sync_bus(sb1), .sync_ch(sc1), .enable_pulse(p1), .ack(ack1), .overrun(ovr1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : mon0
      logic [9:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (p0) begin
            if (q0.size() == 0) chk("dut0 spurious pulse", p0, 0);
            else begin
               e = q0.pop_front();
               chk("dut0 ch", sc0, e[9:8]);
               chk("dut0 data", sb0, e[7:0]);
            end
         end
      end
   end

   initial begin : mon1
      logic [9:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (p1) begin
            if (q1.size() == 0) chk("dut1 spurious pulse", p1, 0);
            else begin
               e = q1.pop_front();
               chk("dut1 ch", sc1, e[9:8]);
               chk("dut1 data", sb1, e[7:0]);
            end
         end
      end
   end

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      bus0 = '0; bus1 = '0; en0 = '0; en1 = '0; clr0 = '0; clr1 = '0;

      // Reset with inputs toggling
      for (int i = 0; i < 3; i++) begin
         tick();
         en0 = 4'($urandom); en1 = 4'($urandom);
         bus0 = $urandom; bus1 = $urandom;
         chk("rst pulse", p0 | p1, 0);
         chk("rst bus", {sb0, sb1}, 0);
         chk("rst ch", {sc0, sc1}, 0);
         chk("rst ack", {ack0, ack1}, 0);
         chk("rst ovr", {ovr0, ovr1}, 0);
      end
      en0 = '0; en1 = '0;
      tick();
      rst0 = 1'b0; rst1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("idle pulse", p0 | p1, 0);
         chk("idle bus", {sb0, sb1}, 0);
         chk("idle ack", {ack0, ack1}, 0);
      end

      // Single channel latency and ack level
      bus0[7:0] = 8'hAB; en0[0] = 1'b1;
      q0.push_back({2'd0, 8'hAB});
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2 early pulse", p0, 0);
      end
      tick();
      chk("t2 pulse", p0, 1);
      chk("t2 bus", sb0, 8'hAB);
      chk("t2 ch", sc0, 0);
      chk("t2 ack set", ack0[0], 1);
      tick();
      chk("t2 one-shot", p0, 0);
      en0[0] = 1'b0;
      tick();
      chk("t2 ack hold", ack0[0], 1);
      tick(2);
      chk("t2 ack clr", ack0[0], 0);
      tick(4);

      // Simultaneous requests, then round-robin order from pointer 0
      bus0 = {8'h33, 8'h22, 8'h11, 8'h00};
      en0 = 4'b1110;
      q0.push_back({2'd1, 8'h11});
      q0.push_back({2'd2, 8'h22});
      q0.push_back({2'd3, 8'h33});
      tick(3);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("t3 pulse", p0, 1);
         chk("t3 order", sc0, i);
      end
      chk("t3 ack", ack0, 4'b1110);
      tick();
      chk("t3 gap", p0, 0);
      en0 = '0;
      tick(4);
      chk("t3 ack clr", ack0, 0);
      bus0 = {8'hC3, 16'h0000, 8'h5A};
      en0 = 4'b1001;
      q0.push_back({2'd0, 8'h5A});
      q0.push_back({2'd3, 8'hC3});
      tick(6);
      chk("t3 ack rr", ack0, 4'b1001);
      en0 = '0;
      tick(5);
      chk("t3 ack clr2", ack0, 0);

      // Overrun in toggle mode
      bus1 = {8'h44, 8'h33, 8'h22, 8'h11};
      en1 = 4'hF;
      q1.push_back({2'd0, 8'h11});
      q1.push_back({2'd1, 8'h22});
      q1.push_back({2'd2, 8'h33});
      q1.push_back({2'd3, 8'h44});
      tick();
      en1[3] = ~en1[3];
      tick(2);
      bus1[31:24] = 8'h99;
      tick();
      chk("t4 first pulse", p1, 1);
      chk("t4 ovr set", ovr1, 4'b1000);
      tick(3);
      chk("t4 ack", ack1, 4'hF);
      tick();
      chk("t4 ovr sticky", ovr1, 4'b1000);
      clr1[3] = 1'b1;
      tick();
      clr1 = '0;
      chk("t4 ovr clr", ovr1, 0);
      tick(4);
      en1 = '0; rst1 = 1'b1;
      tick(3);
      rst1 = 1'b0;
      tick(2);
      chk("t4 rst ack", ack1, 0);

      // Toggle mode on ch2, ack alternates per delivery
      for (int i = 0; i < 3; i++) begin
         bus1[23:16] = 8'(i + 1);
         en1[2] = ~en1[2];
         q1.push_back({2'd2, 8'(i + 1)});
         tick(10);
         chk("t5 ack", ack1[2], (i % 2 == 0) ? 1 : 0);
      end

      // Reset while a word is pending
      bus0[15:8] = 8'hCD; en0[1] = 1'b1;
      tick(3);
      rst0 = 1'b1; en0 = '0;
      tick(3);
      rst0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t6 no pulse", p0, 0);
      end
      chk("t6 ack", ack0[1], 0);

      for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick();
      chk("dut0 drain", q0.size(), 0);
      chk("dut1 drain", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
